wptr_full_ctrl: RTL and testbench

//  Write-side pointer and full-flag logic for the async-compare FIFO, in the wclk domain.
//  - Accepts write requests.
//  - Drives the binary RAM write address and the Gray write pointer to the async comparator.
//  - Consumes the comparator's asynchronous afull_n and turns it into a wclk-domain wfull

---
 rtl/wptr_full_ctrl.sv | 91 +++++++++
 tb/tb_wptr_full_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and full-flag control for an async-compare FIFO (wclk domain).
//
// Counts accepted writes in binary (waddr to the RAM) and in Gray code (wptr to the
// asynchronous comparator). The comparator's unsynchronised, active-low afull_n is
// converted into wfull: it asserts immediately and de-asserts only after afull_n has
// stayed high across two rising wclk edges. Writes attempted while full set a sticky
// woverflow bit, cleared by ovf_clr.
//
// Ports:
//   wclk      in   write-domain clock, rising edge
//   wrst_n    in   asynchronous active-low reset
//   winc      in   write request
//   afull_n   in   async full indication from the comparator, active-low
//   ovf_clr   in   synchronous clear of woverflow
//   wptr      out  registered Gray write pointer
//   waddr     out  registered binary RAM write address
//   wclken    out  RAM write enable (combinational)
//   wfull     out  full flag
//   woverflow out  sticky overflow flag
module wptr_full_ctrl #(
    parameter int unsigned ADDRSIZE = 5
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic                afull_n,
    input  logic                ovf_clr,
    output logic [ADDRSIZE-1:0] wptr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic                wclken,
    output logic                wfull,
    output logic                woverflow
);

    logic [ADDRSIZE-1:0] wbin;
    logic [ADDRSIZE-1:0] wbinnext;
    logic [ADDRSIZE-1:0] wgraynext;
    logic                wfull2;
    logic                blk;
    logic                acc;

    // ~afull_n covers the window after reset release before wfull has caught up.
    assign blk    = wfull | ~afull_n;
    // wrst_n gating drops a write that is in flight when reset asserts.
    assign acc    = winc & ~blk & wrst_n;
    assign wclken = acc;

    always_comb begin
        wbinnext  = wbin + {{(ADDRSIZE-1){1'b0}}, acc};
        wgraynext = (wbinnext >> 1) ^ wbinnext;
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin <= '0;
            wptr <= '0;
        end else begin
            wbin <= wbinnext;
            wptr <= wgraynext;
        end
    end

    assign waddr = wbin;

    // Asynchronous set on afull_n falling; de-assertion ripples through wfull2 so
    // wfull only drops on the second edge after afull_n has risen.
    always_ff @(posedge wclk or negedge wrst_n or negedge afull_n) begin
        if (!wrst_n) begin
            wfull  <= 1'b0;
            wfull2 <= 1'b0;
        end else if (!afull_n) begin
            wfull  <= 1'b1;
            wfull2 <= 1'b1;
        end else begin
            wfull  <= wfull2;
            wfull2 <= 1'b0;
        end
    end

    // Set has priority over clear on the same edge.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            woverflow <= 1'b0;
        end else if (winc & blk) begin
            woverflow <= 1'b1;
        end else if (ovf_clr) begin
            woverflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wptr_full_ctrl.sv
module tb_wptr_full_ctrl;

    logic       wclk = 1'b0;
    logic       wrst_n = 1'b0;
    logic       winc = 1'b0;
    logic       afull_n = 1'b1;
    logic       ovf_clr = 1'b0;
    logic [4:0] wptr;
    logic [4:0] waddr;
    logic       wclken;
    logic       wfull;
    logic       woverflow;

    wptr_full_ctrl #(.ADDRSIZE(5)) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .winc      (winc),
        .afull_n   (afull_n),
        .ovf_clr   (ovf_clr),
        .wptr      (wptr),
        .waddr     (waddr),
        .wclken    (wclken),
        .wfull     (wfull),
        .woverflow (woverflow)
    );

    always #5 wclk = ~wclk;

    int npass = 0;
    int ntotal = 0;

    // Reference model: number of accepted writes, edges left before wfull drops,
    // and the sticky overflow bit.
    int m_cnt = 0;
    int m_hold = 0;
    bit m_ovf = 1'b0;

    function automatic logic [4:0] gray(input int b);
        logic [4:0] x;
        x = b[4:0];
        return x ^ (x >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic set_afull(input logic v);
        if (afull_n && !v && wrst_n) m_hold = 2;
        afull_n = v;
    endtask

    function automatic logic exp_clken();
        return winc && !((m_hold > 0) || !afull_n) && wrst_n;
    endfunction

    task automatic post_checks(input string tag);
        chk({tag, " waddr"}, 32'(waddr), 32'(m_cnt % 32));
        chk({tag, " wptr"}, 32'(wptr), 32'(gray(m_cnt % 32)));
        chk({tag, " wfull"}, 32'(wfull), 32'(m_hold > 0));
        chk({tag, " woverflow"}, 32'(woverflow), 32'(m_ovf));
    endtask

    // Called in the low phase; returns at the next falling edge.
    task automatic edge_and_check(input string tag);
        bit blk;
        bit acc;
        blk = (m_hold > 0) || !afull_n;
        acc = winc && !blk && wrst_n;
        @(posedge wclk);
        m_cnt = (m_cnt + int'(acc)) % 32;
        if (winc && blk) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        if (!afull_n) m_hold = 2;
        else if (m_hold > 0) m_hold--;
        #1;
        post_checks(tag);
        @(negedge wclk);
    endtask

    task automatic step(input logic w, input logic o, input logic a, output logic ck);
        winc = w;
        ovf_clr = o;
        set_afull(a);
        #1;
        ck = wclken;
        chk("wclken", 32'(wclken), 32'(exp_clken()));
        edge_and_check("step");
    endtask

    task automatic reset_dut(input logic w, input logic a);
        wrst_n = 1'b0;
        winc = w;
        afull_n = a;
        ovf_clr = 1'b0;
        m_cnt = 0;
        m_hold = 0;
        m_ovf = 1'b0;
        #1;
        chk("rst wptr", 32'(wptr), 32'd0);
        chk("rst waddr", 32'(waddr), 32'd0);
        chk("rst wfull", 32'(wfull), 32'd0);
        chk("rst wclken", 32'(wclken), 32'd0);
        chk("rst woverflow", 32'(woverflow), 32'd0);
        @(posedge wclk);
        #1;
        post_checks("rst held");
        chk("rst held wclken", 32'(wclken), 32'd0);
        @(negedge wclk);
        wrst_n = 1'b1;
    endtask

    typedef struct {
        logic       w;
        logic       o;
        logic       a;
        logic       e_clken;
        logic [4:0] e_waddr;
        logic [4:0] e_wptr;
        logic       e_full;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic ck;
        logic [4:0] prev;

        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 5'b00001, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 5'b00011, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 5'b00011, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 5'b00011, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd2, 5'b00011, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'd2, 5'b00011, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 5'b00010, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 5'b00110, 1'b0, 1'b0};

        @(negedge wclk);
        // Reset dominates winc=1/afull_n=0, then release while afull_n is still low.
        reset_dut(1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, ck);
        chk("release wclken", 32'(ck), 32'd0);
        chk("release wptr", 32'(wptr), 32'd0);
        chk("release wfull", 32'(wfull), 32'd1);

        // Table of hand-computed vectors from a clean reset.
        reset_dut(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].w, vecs[i].o, vecs[i].a, ck);
            chk($sformatf("vec%0d wclken", i), 32'(ck), 32'(vecs[i].e_clken));
            chk($sformatf("vec%0d waddr", i), 32'(waddr), 32'(vecs[i].e_waddr));
            chk($sformatf("vec%0d wptr", i), 32'(wptr), 32'(vecs[i].e_wptr));
            chk($sformatf("vec%0d wfull", i), 32'(wfull), 32'(vecs[i].e_full));
            chk($sformatf("vec%0d woverflow", i), 32'(woverflow), 32'(vecs[i].e_ovf));
        end

        // Wrap: 33 consecutive writes.
        reset_dut(1'b0, 1'b1);
        for (int i = 0; i < 33; i++) begin
            prev = wptr;
            chk("wrap waddr before", 32'(waddr), 32'(i % 32));
            step(1'b1, 1'b0, 1'b1, ck);
            chk("wrap gray 1-bit", 32'($countones(prev ^ wptr)), 32'd1);
            if (i == 30) chk("wrap wptr@31", 32'(wptr), 32'b10000);
            if (i == 31) chk("wrap wptr@32", 32'(wptr), 32'b00000);
        end

        // Full set mid-cycle without a clock edge, then 3 blocked writes.
        winc = 1'b1;
        ovf_clr = 1'b0;
        #2;
        set_afull(1'b0);
        #1;
        chk("async wfull", 32'(wfull), 32'd1);
        chk("async wclken", 32'(wclken), 32'd0);
        edge_and_check("full e1");
        chk("full ovf e1", 32'(woverflow), 32'd1);
        step(1'b1, 1'b0, 1'b0, ck);
        step(1'b1, 1'b0, 1'b0, ck);
        chk("full waddr frozen", 32'(waddr), 32'd1);
        chk("full wptr frozen", 32'(wptr), 32'b00001);

        // Full clear: two edges with afull_n high.
        step(1'b0, 1'b0, 1'b1, ck);
        chk("clr e1 wfull", 32'(wfull), 32'd1);
        step(1'b0, 1'b0, 1'b1, ck);
        chk("clr e2 wfull", 32'(wfull), 32'd0);
        // Again, with a low pulse between edges 1 and 2.
        step(1'b0, 1'b0, 1'b0, ck);
        step(1'b0, 1'b0, 1'b1, ck);
        chk("pulse e1 wfull", 32'(wfull), 32'd1);
        set_afull(1'b0);
        #1;
        set_afull(1'b1);
        chk("pulse wfull", 32'(wfull), 32'd1);
        step(1'b0, 1'b0, 1'b1, ck);
        chk("pulse+1 wfull", 32'(wfull), 32'd1);
        step(1'b0, 1'b0, 1'b1, ck);
        chk("pulse+2 wfull", 32'(wfull), 32'd0);

        // Overflow clear, then set-and-clear on the same edge.
        chk("ovf still set", 32'(woverflow), 32'd1);
        step(1'b0, 1'b1, 1'b1, ck);
        chk("ovf cleared", 32'(woverflow), 32'd0);
        step(1'b1, 1'b0, 1'b0, ck);
        step(1'b1, 1'b1, 1'b0, ck);
        chk("ovf set wins", 32'(woverflow), 32'd1);

        // Randomised traffic against the model, with occasional pulses and resets.
        for (int i = 0; i < 400; i++) begin
            logic w;
            logic o;
            logic a;
            w = ($urandom_range(9) < 7);
            o = ($urandom_range(9) == 0);
            a = ($urandom_range(19) > 2);
            if ($urandom_range(49) == 0) begin
                reset_dut(w, a);
            end else begin
                winc = w;
                ovf_clr = o;
                set_afull(a);
                #1;
                chk("rnd wclken", 32'(wclken), 32'(exp_clken()));
                if ($urandom_range(9) == 0) begin
                    set_afull(1'b0);
                    #1;
                    chk("rnd pulse wfull", 32'(wfull), 32'd1);
                    chk("rnd pulse wclken", 32'(wclken), 32'd0);
                    set_afull(1'b1);
                end
                edge_and_check("rnd");
            end
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
